// File: rtl/rst_seq_gen_pkg.sv
// Shared types and sizing helpers for the staged reset sequencer.
// Pure declarations: no logic, no latency, no backpressure.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_REL  = 2'd1,
        S_DONE = 2'd2,
        S_HOLD = 2'd3
    } seq_state_e;

    localparam int DEF_NOUT  = 4;
    localparam int DEF_DLY   = 1;
    localparam int DEF_NSYNC = 2;

    function automatic int cnt_width(input int dly);
        return (dly < 1) ? 1 : $clog2(dly + 1);
    endfunction

    function automatic int idx_width(input int nout);
        return (nout <= 2) ? 1 : $clog2(nout);
    endfunction

endpackage

// File: rtl/rst_seq_gen_if.sv
// Reset fan-out bundle between the sequencer (master) and the per-domain consumers (slave).
// Wires only: no latency, no backpressure.
interface rst_seq_gen_if #(
    parameter int NOUT = rst_seq_pkg::DEF_NOUT
) ();
    logic            SRST;
    logic [NOUT-1:0] NRST;
    logic [NOUT-1:0] NPLS;
    logic            DONE;

    modport master (input SRST, output NRST, output NPLS, output DONE);
    modport slave  (output SRST, input NRST, input NPLS, input DONE);
endinterface

// File: rtl/rst_seq_gen_sync.sv
// Async-assert, sync-deassert reset synchronizer, NSTAGE flops deep (NSTAGE >= 1).
// Release latency NSTAGE edges; assertion is immediate; no backpressure.
module rst_sync_n #(
    parameter int NSTAGE = 2
) (
    input  logic CLK,
    input  logic NARST,
    output logic nrst_o
);
    logic [NSTAGE-1:0] sync_q;
    logic [NSTAGE:0]   shift_d;

    assign shift_d = {sync_q, 1'b1};

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            sync_q <= '0;
        end else begin
            sync_q <= shift_d[NSTAGE-1:0];
        end
    end

    assign nrst_o = sync_q[NSTAGE-1];
endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: NOUT active-low resets released DLY cycles apart, each preceded by a one-cycle NPLS low.
// First release NSYNC+DLY edges after NARST rises; SRST holds/restarts the sequence; no backpressure.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int NOUT  = DEF_NOUT,
    parameter int DLY   = DEF_DLY,
    parameter int NSYNC = DEF_NSYNC
) (
    input  logic         CLK,
    input  logic         NARST,
    rst_seq_gen_if.master bus
);
    localparam int CW = cnt_width(DLY);
    localparam int IW = idx_width(NOUT);

    localparam logic [CW-1:0] CNT_TC  = CW'(DLY - 1);
    localparam logic [IW-1:0] IDX_LST = IW'(NOUT - 1);

    logic            sync;
    seq_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [NOUT-1:0] nrst_q, nrst_d;
    logic [NOUT-1:0] npls_q, npls_d;
    logic            done_q, done_d;

    // The state flop acts as the last synchronizer stage, so the WAIT->REL
    // edge is the NSYNC-th edge after NARST rises (edge R).
    rst_sync_n #(.NSTAGE(NSYNC - 1)) u_sync (
        .CLK    (CLK),
        .NARST  (NARST),
        .nrst_o (sync)
    );

    always_ff @(posedge CLK or negedge NARST) begin
        if (!NARST) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
            idx_q   <= '0;
            nrst_q  <= '0;
            npls_q  <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nrst_q  <= nrst_d;
            npls_q  <= npls_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        nrst_d  = nrst_q;
        done_d  = done_q;
        npls_d  = '1;

        unique case (state_q)
            S_WAIT: begin
                if (sync && !bus.SRST) begin
                    state_d = S_REL;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_REL: begin
                if (bus.SRST) begin
                    state_d = S_HOLD;
                end else if (cnt_q == CNT_TC) begin
                    nrst_d[idx_q] = 1'b1;
                    cnt_d         = '0;
                    if (idx_q == IDX_LST) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.SRST) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (!bus.SRST) begin
                    state_d = S_REL;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            default: state_d = S_WAIT;
        endcase

        if (state_d == S_HOLD) begin
            cnt_d  = '0;
            idx_d  = '0;
            nrst_d = '0;
            done_d = 1'b0;
        end

        // Pulse is derived from next-state so it sits exactly one cycle ahead of its release.
        if (state_d == S_REL && cnt_d == CNT_TC) begin
            npls_d[idx_d] = 1'b0;
        end
    end

    assign bus.NRST = nrst_q;
    assign bus.NPLS = npls_q;
    assign bus.DONE = done_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench: DUT a (NOUT=4, DLY=1, NSYNC=2) and DUT b (NOUT=3, DLY=4, NSYNC=2) share CLK and NARST.
module tb_rst_seq_gen;
    logic clk;
    logic narst;
    int   tests;
    int   fails;

    rst_seq_gen_if #(.NOUT(4)) if_a ();
    rst_seq_gen_if #(.NOUT(3)) if_b ();

    rst_seq_gen #(.NOUT(4), .DLY(1), .NSYNC(2)) u_a (
        .CLK   (clk),
        .NARST (narst),
        .bus   (if_a)
    );

    rst_seq_gen #(.NOUT(3), .DLY(4), .NSYNC(2)) u_b (
        .CLK   (clk),
        .NARST (narst),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vectors, rel = edges since R: NRST[k] high once rel >= (k+1)*dly,
    // NPLS[k] low only at rel == (k+1)*dly-1. Negative rel means held in reset.
    function automatic logic [3:0] nrst_exp(input int rel, input int dly, input int n);
        logic [3:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k] = (rel >= (k + 1) * dly);
        return v;
    endfunction

    function automatic logic [3:0] npls_exp(input int rel, input int dly, input int n);
        logic [3:0] v;
        v = '1;
        for (int k = 0; k < n; k++) v[k] = (rel != (k + 1) * dly - 1);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int ra, input int rb);
        chk({tag, " a.NRST"}, if_a.NRST,          nrst_exp(ra, 1, 4));
        chk({tag, " a.NPLS"}, if_a.NPLS,          npls_exp(ra, 1, 4));
        chk({tag, " a.DONE"}, {3'b000, if_a.DONE}, {3'b000, ra >= 4});
        chk({tag, " b.NRST"}, {1'b0, if_b.NRST},   nrst_exp(rb, 4, 3));
        chk({tag, " b.NPLS"}, {1'b1, if_b.NPLS},   npls_exp(rb, 4, 3));
        chk({tag, " b.DONE"}, {3'b000, if_b.DONE}, {3'b000, rb >= 12});
    endtask

    task automatic edge_s;
        @(posedge clk);
        #1;
    endtask

    // Released bits must always form a contiguous run from bit 0.
    always @(negedge clk) begin
        tests++;
        assert ((((if_a.NRST + 4'd1) & if_a.NRST) === 4'd0) &&
                (((if_b.NRST + 3'd1) & if_b.NRST) === 3'd0)) else begin
            fails++;
            $error("FAIL monotonic observed a=%b b=%b expected thermometer", if_a.NRST, if_b.NRST);
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        narst     = 1'b1;
        if_a.SRST = 1'b0;
        if_b.SRST = 1'b0;
        #1 narst  = 1'b0;
        #1;
        check_all("reset_async", -1, -1);
        edge_s();
        edge_s();
        check_all("reset_held", -1, -1);

        // Power-up release: a rises at edges 3..6, b at 6,10,14.
        @(negedge clk) narst = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            edge_s();
            check_all($sformatf("boot e%0d", e), e - 2, e - 2);
        end

        // One-cycle SRST while a is in DONE.
        @(negedge clk) if_a.SRST = 1'b1;
        edge_s();
        check_all("srst_done hold", -1, 1000);
        @(negedge clk) if_a.SRST = 1'b0;
        for (int r = 0; r <= 5; r++) begin
            edge_s();
            check_all($sformatf("srst_done r%0d", r), r, 1000);
        end

        // SRST while NPLS[1] is low: pulse aborted, NRST[0] drops.
        @(negedge clk) if_a.SRST = 1'b1;
        edge_s();
        check_all("abort pre hold", -1, 1000);
        @(negedge clk) if_a.SRST = 1'b0;
        for (int r = 0; r <= 1; r++) begin
            edge_s();
            check_all($sformatf("abort pre r%0d", r), r, 1000);
        end
        @(negedge clk) if_a.SRST = 1'b1;
        edge_s();
        check_all("abort hold", -1, 1000);
        @(negedge clk) if_a.SRST = 1'b0;
        for (int r = 0; r <= 5; r++) begin
            edge_s();
            check_all($sformatf("abort r%0d", r), r, 1000);
        end

        // Short NARST glitch mid-sequence: immediate reset, full NSYNC restart.
        @(negedge clk) if_a.SRST = 1'b1;
        edge_s();
        @(negedge clk) if_a.SRST = 1'b0;
        edge_s();
        edge_s();
        check_all("glitch pre", 1, 1000);
        #1 narst = 1'b0;
        #1;
        check_all("glitch async", -1, -1);
        #1 narst = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            edge_s();
            check_all($sformatf("glitch e%0d", e), e - 2, e - 2);
        end

        // SRST held high across NARST release: nothing moves until SRST drops.
        @(negedge clk) begin
            narst     = 1'b0;
            if_a.SRST = 1'b1;
            if_b.SRST = 1'b1;
        end
        #1;
        check_all("srst_boot async", -1, -1);
        @(negedge clk) narst = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            edge_s();
            check_all($sformatf("srst_boot held e%0d", e), -1, -1);
        end
        @(negedge clk) begin
            if_a.SRST = 1'b0;
            if_b.SRST = 1'b0;
        end
        for (int r = 0; r <= 14; r++) begin
            edge_s();
            check_all($sformatf("srst_boot r%0d", r), r, r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
